// File: rtl/fp_result_packer_if.sv
// Request/result bundle for fp_result_packer: unnormalized result in,
// packed IEEE-style word and exception flags out, each with valid/ready.
interface fp_result_packer_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
);
  localparam int W = MANT_WIDTH + 4;

  logic                            in_valid;
  logic                            in_ready;
  logic                            in_sign;
  logic signed [EXP_WIDTH+1:0]     in_exp;
  logic        [W-1:0]             in_mant;
  logic                            in_invalid;
  logic                            in_nan;
  logic                            in_inf;
  logic                            out_valid;
  logic                            out_ready;
  logic [EXP_WIDTH+MANT_WIDTH:0]   out_result;
  logic                            out_overflow;
  logic                            out_underflow;
  logic                            out_inexact;
  logic                            out_invalid;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_invalid, in_nan, in_inf, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact, out_invalid
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_invalid, in_nan, in_inf, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact, out_invalid
  );
endinterface

// File: rtl/fp_result_packer.sv
// Normalizes, rounds (nearest-even) and packs a floating-point result one
// shift per cycle, with special-case bypass and exception flag generation.
module fp_result_packer #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_result_packer_if.slave bus
);
  localparam int W  = MANT_WIDTH + 4;
  localparam int XW = EXP_WIDTH + 3;
  localparam int RW = EXP_WIDTH + MANT_WIDTH + 1;

  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'(2**EXP_WIDTH - 1);
  localparam logic        [RW-1:0] QNAN    =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t                state_q, state_d;
  logic                  live_q;
  logic                  sign_p0, sign_d;
  logic signed [XW-1:0]  exp_p0, exp_d;
  logic        [W-1:0]   mant_p0, mant_d;
  logic        [RW-1:0]  res_p1, res_d;
  logic                  ovf_p1, ovf_d, unf_p1, unf_d, inx_p1, inx_d, inv_p1, inv_d;

  logic        [W-1:0]   shr;
  logic        [W-3:0]   rnd;
  logic signed [XW-1:0]  rexp;
  logic                  inx_n;

  function automatic logic [W-1:0] shr_sticky(input logic [W-1:0] m);
    return {1'b0, m[W-1:2], m[1] | m[0]};
  endfunction

  // Keeps [W-1:2] and adds the round-to-nearest-even increment.
  function automatic logic [W-3:0] round_rne(input logic [W-1:0] m);
    logic up;
    up = m[1] & (m[0] | m[2]);
    return m[W-1:2] + {{(W-3){1'b0}}, up};
  endfunction

  always_comb begin
    state_d = state_q;
    sign_d  = sign_p0;
    exp_d   = exp_p0;
    mant_d  = mant_p0;
    res_d   = res_p1;
    ovf_d   = ovf_p1;
    unf_d   = unf_p1;
    inx_d   = inx_p1;
    inv_d   = inv_p1;
    shr     = shr_sticky(mant_p0);
    rnd     = '0;
    rexp    = exp_p0;
    inx_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && live_q) begin
          sign_d  = bus.in_sign;
          exp_d   = {bus.in_exp[EXP_WIDTH+1], bus.in_exp};
          mant_d  = bus.in_mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inx_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = OUT;
          if (bus.in_invalid) begin
            res_d = QNAN;
            inv_d = 1'b1;
          end else if (bus.in_nan) begin
            res_d = QNAN;
          end else if (bus.in_inf) begin
            res_d = {bus.in_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          end else if (bus.in_mant == '0) begin
            res_d = {bus.in_sign, {(RW-1){1'b0}}};
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mant_p0[W-1]) begin
          mant_d = shr;
          exp_d  = exp_p0 + ONE;
        end else if (exp_p0 < ONE) begin
          // Denormalizing: once only sticky remains, further shifts change nothing.
          mant_d = shr;
          exp_d  = (shr[W-1:1] == '0) ? ONE : exp_p0 + ONE;
        end else if (mant_p0[W-2] || exp_p0 == ONE) begin
          state_d = ROUND;
        end else begin
          mant_d = mant_p0 << 1;
          exp_d  = exp_p0 - ONE;
        end
      end
      ROUND: begin
        rnd   = round_rne(mant_p0);
        inx_n = mant_p0[1] | mant_p0[0];
        if (rnd[W-3]) begin
          rnd  = rnd >> 1;
          rexp = exp_p0 + ONE;
        end
        ovf_d = 1'b0;
        inv_d = 1'b0;
        if (rexp >= EXP_MAX) begin
          res_d = {sign_p0, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          ovf_d = 1'b1;
          inx_d = 1'b1;
          unf_d = 1'b0;
        end else if (!rnd[W-4]) begin
          res_d = {sign_p0, {EXP_WIDTH{1'b0}}, rnd[W-5:0]};
          inx_d = inx_n;
          unf_d = inx_n;
        end else begin
          res_d = {sign_p0, rexp[EXP_WIDTH-1:0], rnd[W-5:0]};
          inx_d = inx_n;
          unf_d = 1'b0;
        end
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      res_p1  <= '0;
      ovf_p1  <= 1'b0;
      unf_p1  <= 1'b0;
      inx_p1  <= 1'b0;
      inv_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      res_p1  <= res_d;
      ovf_p1  <= ovf_d;
      unf_p1  <= unf_d;
      inx_p1  <= inx_d;
      inv_p1  <= inv_d;
    end
  end

  // Working operand: only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    sign_p0 <= sign_d;
    exp_p0  <= exp_d;
    mant_p0 <= mant_d;
  end

  assign bus.in_ready      = live_q && (state_q == IDLE);
  assign bus.out_valid     = (state_q == OUT);
  assign bus.out_result    = res_p1;
  assign bus.out_overflow  = ovf_p1;
  assign bus.out_underflow = unf_p1;
  assign bus.out_inexact   = inx_p1;
  assign bus.out_invalid   = inv_p1;
endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: directed vector table, stall and reset
// sequences, then random requests against an arithmetic reference model.
module tb_fp_result_packer;
  localparam int EW = 8;
  localparam int MW = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_result_packer_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) bus();
  fp_result_packer #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  typedef struct {
    logic        sign;
    int          e;
    logic [26:0] mant;
    logic        inv;
    logic        nan;
    logic        inf;
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int msb(input longint unsigned m);
    int p;
    p = -1;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Reference: value = mant * 2^(e - bias - 25); flags {ovf, unf, inx, inv}.
  function automatic exp_t model(input logic s, input int e_in, input longint unsigned m_in,
                                 input logic inv, input logic nan, input logic inf);
    exp_t o;
    longint unsigned m, q;
    int e, cyc, n, k, sh;
    logic g, st, lsb, ovf, unf, inx;
    o.res = '0; o.flags = '0; o.lat = 1;
    m = m_in; e = e_in; cyc = 0;
    if (inv) begin o.res = 32'h7FC00000; o.flags = 4'b0001; return o; end
    if (nan) begin o.res = 32'h7FC00000; return o; end
    if (inf) begin o.res = {s, 8'hFF, 23'h0}; return o; end
    if (m == 0) begin o.res = {s, 31'h0}; return o; end
    if (m >= (64'd1 << 26)) begin
      m = (m >> 1) | (m & 64'd1);
      e++; cyc++;
    end
    if (e < 1) begin
      n = 1 - e;
      k = msb(m); if (k < 1) k = 1;
      cyc += (n < k) ? n : k;
      if (n >= 27) m = (m != 0) ? 64'd1 : 64'd0;
      else m = (m >> n) | (((m & ((64'd1 << n) - 1)) != 0) ? 64'd1 : 64'd0);
      e = 1;
    end else begin
      sh = 25 - msb(m);
      if (sh > e - 1) sh = e - 1;
      m = m << sh; e -= sh; cyc += sh;
    end
    q = m >> 2; g = m[1]; st = m[0]; lsb = q[0];
    inx = g | st; ovf = 1'b0; unf = 1'b0;
    if (g && (st || lsb)) q++;
    if (q >= (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) begin
      o.res = {s, 8'hFF, 23'h0}; ovf = 1'b1; inx = 1'b1;
    end else if (q < (64'd1 << 23)) begin
      o.res = {s, 8'h00, q[22:0]}; unf = inx;
    end else begin
      o.res = {s, 8'(e), q[22:0]};
    end
    o.flags = {ovf, unf, inx, 1'b0};
    o.lat = 3 + cyc;
    return o;
  endfunction

  // Called at a negedge with out_ready high; returns at a negedge in IDLE.
  task automatic run_one(input string tag, input logic s, input int e, input logic [26:0] m,
                         input logic inv, input logic nan, input logic inf,
                         input logic [31:0] req_res, input logic [3:0] req_fl, input int req_lat);
    int lat;
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_sign = s; bus.in_exp = 10'(e); bus.in_mant = m;
    bus.in_invalid = inv; bus.in_nan = nan; bus.in_inf = inf;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_res"}, 64'(bus.out_result), 64'(req_res));
    check({tag, "_flags"}, 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_invalid}),
          64'(req_fl));
    check({tag, "_lat"}, 64'(lat), 64'(req_lat));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    exp_t ex;
    logic s, inv, nan, inf, saw;
    int e, r;
    logic [26:0] m;

    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_invalid = 1'b0; bus.in_nan = 1'b0; bus.in_inf = 1'b0; bus.out_ready = 1'b1;

    tbl[0]  = '{1'b0, 127, 27'h2000000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0000, 3};
    tbl[1]  = '{1'b0,   5, 27'h1234567, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 4'b0001, 1};
    tbl[2]  = '{1'b1, 200, 27'h2000000, 1'b0, 1'b0, 1'b1, 32'hFF800000, 4'b0000, 1};
    tbl[3]  = '{1'b0, 254, 27'h3FFFFFE, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b1010, 3};
    tbl[4]  = '{1'b0, 127, 27'h0800000, 1'b0, 1'b0, 1'b0, 32'h3E800000, 4'b0000, 5};
    tbl[5]  = '{1'b0,   0, 27'h2000000, 1'b0, 1'b0, 1'b0, 32'h00400000, 4'b0000, 4};
    tbl[6]  = '{1'b0,   0, 27'h2000001, 1'b0, 1'b0, 1'b0, 32'h00400000, 4'b0110, 4};
    tbl[7]  = '{1'b1, 127, 27'h4000000, 1'b0, 1'b0, 1'b0, 32'hC0000000, 4'b0000, 4};
    tbl[8]  = '{1'b1,   3, 27'h0000000, 1'b0, 1'b1, 1'b0, 32'h7FC00000, 4'b0000, 1};
    tbl[9]  = '{1'b1,  50, 27'h0000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b0000, 1};
    tbl[10] = '{1'b0, 127, 27'h2000002, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0010, 3};
    tbl[11] = '{1'b0, 127, 27'h2000006, 1'b0, 1'b0, 1'b0, 32'h3F800002, 4'b0010, 3};
    tbl[12] = '{1'b1,  90, 27'h2000000, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 4'b0001, 1};
    tbl[13] = '{1'b1,  90, 27'h2000000, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 4'b0000, 1};

    repeat (3) @(negedge clk);
    check("reset_state", 64'({bus.in_ready, bus.out_valid, bus.out_result, bus.out_overflow,
                              bus.out_underflow, bus.out_inexact, bus.out_invalid}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 14; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].sign, tbl[i].e, tbl[i].mant, tbl[i].inv,
              tbl[i].nan, tbl[i].inf, tbl[i].res, tbl[i].flags, tbl[i].lat);

    // Consumer stall: output must hold for 10 cycles with no new acceptance.
    bus.out_ready = 1'b0;
    bus.in_sign = 1'b0; bus.in_exp = 10'd0; bus.in_mant = 27'h2000001;
    bus.in_invalid = 1'b0; bus.in_nan = 1'b0; bus.in_inf = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    r = 0;
    while (!bus.out_valid && r < 50) begin @(negedge clk); r++; end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall%0d", i),
            64'({bus.out_valid, bus.in_ready, bus.out_result, bus.out_overflow,
                 bus.out_underflow, bus.out_inexact, bus.out_invalid}),
            64'({1'b1, 1'b0, 32'h00400000, 4'b0110}));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));

    // Reset pulse while the request is still shifting in NORM.
    bus.in_sign = 1'b0; bus.in_exp = 10'd127; bus.in_mant = 27'h0000001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 64'({bus.out_valid, bus.in_ready, bus.out_result}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1'b1;
    end
    check("rst_discard", 64'(saw), 64'd0);

    for (int i = 0; i < 250; i++) begin
      s = 1'($urandom);
      r = int'($urandom_range(0, 15));
      inv = (r == 0); nan = (r == 1); inf = (r == 2);
      if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 1023)) - 512;
      else e = int'($urandom_range(0, 400)) - 100;
      case ($urandom_range(0, 7))
        0:       m = 27'd0;
        1, 2:    m = 27'($urandom) >> $urandom_range(1, 26);
        3:       m = 27'h3FFFFFC | 27'($urandom_range(0, 3));
        default: m = 27'($urandom);
      endcase
      ex = model(s, e, longint'(m), inv, nan, inf);
      run_one($sformatf("rnd%0d", i), s, e, m, inv, nan, inf, ex.res, ex.flags, ex.lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_result_packer.md
FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 Parameter MANT_WIDTH, default 23, stored fraction width; W = MANT_WIDTH+4 is the internal mantissa width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request.
REQ-007 in_sign  input  1  result sign.
REQ-008 in_exp  input  EXP_WIDTH+2  signed two's-complement biased exponent.
REQ-009 in_mant  input  W  unnormalized magnitude: [W-1] carry, [W-2] hidden, [W-3:2] fraction, [1] guard, [0] sticky.
REQ-010 in_invalid, in_nan, in_inf  input  1 each  special-case flags from the operand/operation classifiers.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_result  output  EXP_WIDTH+MANT_WIDTH+1  packed [sign][exp][fraction].
REQ-014 out_overflow, out_underflow, out_inexact, out_invalid  output  1 each  exception flags, valid with out_valid.

Function
REQ-015 FSM states IDLE, NORM, ROUND, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-016 IDLE: on in_valid, capture all inputs; go to OUT if any special flag set, or if in_mant==0; otherwise go to NORM.
REQ-017 Special precedence: in_invalid -> canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0), out_invalid=1; else in_nan -> canonical NaN, out_invalid=0; else in_inf -> exp all ones, fraction 0, in_sign kept; else in_mant==0 -> signed zero. All other flags are 0 for these cases.
REQ-018 NORM performs one action per cycle, evaluated in this priority order:
- carry bit set: shift right 1, OR the shifted-out bit into sticky, exp+1.
- exp<1: shift right 1 with sticky OR, exp+1; when in_mant[W-1:1] becomes zero, force exp=1 immediately.
- hidden set or exp==1: go to ROUND.
- otherwise: shift left 1, exp-1.
REQ-019 ROUND applies round-to-nearest-even with lsb=[2], guard=[1], sticky=[0]. Round up if guard && (sticky || lsb). inexact = guard || sticky.
REQ-020 If the round-up carries into the carry bit: shift right 1, exp+1, in the same cycle; ROUND always exits to OUT after one cycle.
REQ-021 Packing:
- exp >= 2^EXP_WIDTH-1: signed infinity, overflow=1, inexact=1.
- hidden=0 at exp==1: exp field 0 (denormal/zero).
- otherwise exp field = exp[EXP_WIDTH-1:0] and fraction = [W-3:2].
REQ-022 out_underflow = (result denormal or zero after rounding) && inexact.
REQ-023 OUT holds out_result and flags stable until out_valid && out_ready, then goes to IDLE; no new request is accepted in the same cycle.
REQ-024 Latency from accept edge to out_valid: 1 cycle for special or zero input; otherwise 3 + number of NORM shift cycles.
REQ-025 NORM cycle count is bounded by W+1.

Reset
REQ-026 rst_n low asynchronously forces state IDLE and clears out_valid, out_result, and all flags to 0; in_ready=0 while rst_n low.
REQ-027 Reset mid-operation discards the captured request; no partial result is emitted after release.
REQ-028 in_ready=1 on the first clock edge after rst_n deasserts.

Verification
REQ-029 sign=0, exp=127, mant=27'h2000000 -> 0x3F800000, all flags 0, out_valid 3 cycles after accept.
REQ-030 in_invalid=1 (mant arbitrary) -> 0x7FC00000, out_invalid=1, latency 1; in_inf=1, sign=1 -> 0xFF800000.
REQ-031 exp=254, mant=27'h3FFFFFE -> rounds into carry -> 0x7F800000, overflow=1, inexact=1.
REQ-032 exp=127, mant=27'h0800000 -> two left shifts -> 0x3E800000, latency 5.
REQ-033 exp=0, mant=27'h2000000 -> 0x00400000, underflow=0, inexact=0; exp=0, mant=27'h2000001 -> underflow=1, inexact=1.
REQ-034 out_ready=0 for 10 cycles -> result and flags stable, in_ready=0; rst_n pulse during NORM -> out_valid never asserts for that request, in_ready=1 after release.
